// File: rtl/lrelu_beats_sequencer_if.sv
// Beat-sequencer bundle between the LReLU config path and the engine's
// D-register / BRAM write-select and address logic.
interface lrelu_beats_sequencer_if #(
    parameter int MEMBERS  = 8,
    parameter int LANES    = 4,
    parameter int KH_MAX   = 11,
    parameter int KW_MAX   = 11,
    parameter int BITS_KH2 = $clog2(KH_MAX / 2 + 1),
    parameter int BITS_KW2 = $clog2(KW_MAX / 2 + 1)
);
    localparam int KM_MAX = (KH_MAX > KW_MAX) ? KH_MAX : KW_MAX;
    localparam int CLR_I_MAX = KM_MAX / 2;
    localparam int BITS_CLR_I =
        (CLR_I_MAX > 0) ? $clog2(CLR_I_MAX + 1) : 1;
    localparam int BITS_MTB = (KH_MAX > 1) ? $clog2(KH_MAX) : 1;
    localparam int A_MAX = KW_MAX / 2 + 1;
    localparam int B_MAX = (KW_MAX * MEMBERS + LANES - 1) / LANES;
    localparam int W_ADDR_MAX = (A_MAX > B_MAX) ? A_MAX : B_MAX;
    localparam int BITS_W_ADDR =
        (W_ADDR_MAX > 1) ? $clog2(W_ADDR_MAX) : 1;

    logic                   en;
    logic                   restart;
    logic [BITS_KH2-1:0]    kh2;
    logic [BITS_KW2-1:0]    kw2;
    logic                   skip_a;
    logic [1:0]             w_sel;
    logic [BITS_CLR_I-1:0]  clr_i;
    logic [BITS_MTB-1:0]    mtb;
    logic [BITS_W_ADDR-1:0] w_addr;
    logic                   first;
    logic                   full;

    modport master (
        output en, restart, kh2, kw2, skip_a,
        input  w_sel, clr_i, mtb, w_addr, first, full
    );

    modport slave (
        input  en, restart, kh2, kw2, skip_a,
        output w_sel, clr_i, mtb, w_addr, first, full
    );
endinterface

// File: rtl/lrelu_beats_sequencer.sv
// LReLU parameter-block beat sequencer: D beat, BRAM_A beats, then nested
// BRAM_B beats over (clr_i, mtb, w_addr), with latched block configuration.
module lrelu_beats_sequencer #(
    parameter int MEMBERS  = 8,
    parameter int LANES    = 4,
    parameter int KH_MAX   = 11,
    parameter int KW_MAX   = 11,
    parameter int BITS_KH2 = $clog2(KH_MAX / 2 + 1),
    parameter int BITS_KW2 = $clog2(KW_MAX / 2 + 1)
) (
    input logic clk,
    input logic rstn,
    lrelu_beats_sequencer_if.slave bus
);
    localparam int KM_MAX = (KH_MAX > KW_MAX) ? KH_MAX : KW_MAX;
    localparam int CLR_I_MAX = KM_MAX / 2;
    localparam int BITS_CLR_I =
        (CLR_I_MAX > 0) ? $clog2(CLR_I_MAX + 1) : 1;
    localparam int BITS_MTB = (KH_MAX > 1) ? $clog2(KH_MAX) : 1;
    localparam int A_MAX = KW_MAX / 2 + 1;
    localparam int B_MAX = (KW_MAX * MEMBERS + LANES - 1) / LANES;
    localparam int W_ADDR_MAX = (A_MAX > B_MAX) ? A_MAX : B_MAX;
    localparam int BITS_W_ADDR =
        (W_ADDR_MAX > 1) ? $clog2(W_ADDR_MAX) : 1;
    localparam int KW2_LIM = KW_MAX / 2;
    localparam int LUT_N = 2 ** BITS_KW2;

    typedef enum logic [1:0] {
        REG_D  = 2'd1,
        BRAM_A = 2'd2,
        BRAM_B = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic [BITS_CLR_I-1:0]  clr_q, clr_n;
    logic [BITS_MTB-1:0]    mtb_q, mtb_n;
    logic [BITS_W_ADDR-1:0] addr_q, addr_n;
    logic [BITS_KH2-1:0]    kh2_q, kh2_n;
    logic [BITS_KW2-1:0]    kw2_q, kw2_n;
    logic                   skip_q, skip_n;

    logic [BITS_W_ADDR-1:0] b_lut [LUT_N];
    logic [BITS_KW2-1:0]    c_eff;
    logic [BITS_W_ADDR-1:0] b_last;
    logic [BITS_MTB-1:0]    mtb_last;
    logic [BITS_CLR_I-1:0]  clr_last;
    logic                   a_wrap;
    logic                   b_wrap;
    logic                   m_wrap;
    logic                   c_done;
    logic                   full;

    // Last BRAM_B address per effective clr index, clamped past KW_MAX/2.
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam int KC = (k < KW2_LIM) ? k : KW2_LIM;
        localparam int LAST = ((2 * KC + 1) * MEMBERS + LANES - 1) / LANES - 1;
        assign b_lut[k] = BITS_W_ADDR'(LAST);
    end

    always_comb begin
        if (int'(clr_q) < int'(kw2_q)) begin
            c_eff = BITS_KW2'(clr_q);
        end else begin
            c_eff = kw2_q;
        end
    end

    assign b_last = b_lut[c_eff];

    assign mtb_last = BITS_MTB'(
        (int'(clr_q) < int'(kh2_q)) ? 2 * int'(clr_q) : 2 * int'(kh2_q));

    assign clr_last = BITS_CLR_I'(
        (int'(kh2_q) > int'(kw2_q)) ? int'(kh2_q) : int'(kw2_q));

    assign a_wrap = (addr_q == BITS_W_ADDR'(kw2_q));
    assign b_wrap = (addr_q == b_last);
    assign m_wrap = (mtb_q == mtb_last);
    assign c_done = (clr_q == clr_last);
    assign full   = (state == BRAM_B) && b_wrap && m_wrap && c_done;

    always_comb begin
        state_n = state;
        clr_n   = clr_q;
        mtb_n   = mtb_q;
        addr_n  = addr_q;
        kh2_n   = kh2_q;
        kw2_n   = kw2_q;
        skip_n  = skip_q;
        if (bus.restart) begin
            state_n = REG_D;
            clr_n   = '0;
            mtb_n   = '0;
            addr_n  = '0;
        end else if (bus.en) begin
            unique case (state)
                REG_D: begin
                    kh2_n   = bus.kh2;
                    kw2_n   = bus.kw2;
                    skip_n  = bus.skip_a;
                    state_n = bus.skip_a ? BRAM_B : BRAM_A;
                    clr_n   = '0;
                    mtb_n   = '0;
                    addr_n  = '0;
                end
                BRAM_A: begin
                    if (a_wrap) begin
                        state_n = BRAM_B;
                        addr_n  = '0;
                    end else begin
                        addr_n = addr_q + BITS_W_ADDR'(1);
                    end
                end
                BRAM_B: begin
                    if (full) begin
                        state_n = REG_D;
                        clr_n   = '0;
                        mtb_n   = '0;
                        addr_n  = '0;
                    end else if (b_wrap) begin
                        addr_n = '0;
                        if (m_wrap) begin
                            mtb_n = '0;
                            clr_n = clr_q + BITS_CLR_I'(1);
                        end else begin
                            mtb_n = mtb_q + BITS_MTB'(1);
                        end
                    end else begin
                        addr_n = addr_q + BITS_W_ADDR'(1);
                    end
                end
                default: begin
                    state_n = REG_D;
                    clr_n   = '0;
                    mtb_n   = '0;
                    addr_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= REG_D;
            clr_q  <= '0;
            mtb_q  <= '0;
            addr_q <= '0;
            kh2_q  <= '0;
            kw2_q  <= '0;
            skip_q <= 1'b0;
        end else begin
            state  <= state_n;
            clr_q  <= clr_n;
            mtb_q  <= mtb_n;
            addr_q <= addr_n;
            kh2_q  <= kh2_n;
            kw2_q  <= kw2_n;
            skip_q <= skip_n;
        end
    end

    assign bus.w_sel  = state;
    assign bus.clr_i  = clr_q;
    assign bus.mtb    = mtb_q;
    assign bus.w_addr = addr_q;
    assign bus.first  = (state == REG_D);
    assign bus.full   = full;
endmodule
